// File: rtl/eth_packet_checker_pkg.sv
// Shared types and constants for the RX pattern checker.
package eth_packet_checker_pkg;

  // Beat layout: [15:0] beat index, [63:16] constant pattern.
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = 8;
  localparam int unsigned PAT_LSB = 16;

  // Bit positions inside err_flags.
  localparam int unsigned ERR_INDEX  = 0;
  localparam int unsigned ERR_DATA   = 1;
  localparam int unsigned ERR_KEEP   = 2;
  localparam int unsigned ERR_LENGTH = 3;
  localparam int unsigned ERR_TUSER  = 4;
  localparam int unsigned ERR_W      = 5;

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_e;

endpackage

// File: rtl/eth_packet_checker_sat.sv
// Saturating event counter with synchronous clear.
// Ports: i_clk, i_rst_n (async active-low), i_clr (clear wins over i_inc),
//        i_inc (count one event), o_count (registered value, sticks at all-ones).
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/eth_packet_checker.sv
// Checks the eth_10g RX AXIS stream against the example generator pattern
// and keeps saturating statistics plus sticky error flags.
// Ports: s00_axis_* RX stream (no tready), packet_length = last beat index,
//        expected_data[63:16] = pattern constant, clear = sync stats clear;
//        outputs locked, pkt_count, bad_pkt_count, beat_err_count, err_flags
//        {tuser, length, keep, data, index}, all registered.
module eth_packet_checker
  import eth_packet_checker_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned IDX_WIDTH = 16
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_aresetn,
  input  logic [DATA_W-1:0]    s00_axis_tdata,
  input  logic [KEEP_W-1:0]    s00_axis_tkeep,
  input  logic                 s00_axis_tvalid,
  input  logic                 s00_axis_tlast,
  input  logic                 s00_axis_tuser,
  input  logic [IDX_WIDTH-1:0] packet_length,
  input  logic [DATA_W-1:0]    expected_data,
  input  logic                 clear,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] bad_pkt_count,
  output logic [CNT_WIDTH-1:0] beat_err_count,
  output logic [ERR_W-1:0]     err_flags
);

  state_e               r_state;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [IDX_WIDTH-1:0] r_len;
  logic                 r_bad;
  logic [ERR_W-1:0]     r_err_flags;

  state_e               w_state_nxt;
  logic [IDX_WIDTH-1:0] w_idx_nxt;
  logic [IDX_WIDTH-1:0] w_len_nxt;
  logic                 w_bad_nxt;
  logic [ERR_W-1:0]     w_flags_nxt;
  logic                 w_pkt_inc;
  logic                 w_bad_pkt_inc;
  logic                 w_beat_err_inc;

  logic [IDX_WIDTH-1:0] w_len_cur;
  logic                 w_at_len;
  logic [ERR_W-1:0]     w_err;
  logic                 w_beat_err;
  logic                 w_unused;

  // Index 0 takes the live length so a config change applies from the next packet on.
  assign w_len_cur = (r_idx == '0) ? packet_length : r_len;
  assign w_at_len  = (r_idx == w_len_cur);

  // Per-beat mismatch vector, only meaningful while a beat is valid in CHECK.
  always_comb begin
    w_err             = '0;
    w_err[ERR_INDEX]  = (IDX_WIDTH'(s00_axis_tdata[PAT_LSB-1:0]) != r_idx);
    w_err[ERR_DATA]   = (s00_axis_tdata[DATA_W-1:PAT_LSB] != expected_data[DATA_W-1:PAT_LSB]);
    w_err[ERR_KEEP]   = (s00_axis_tkeep != {KEEP_W{1'b1}});
    w_err[ERR_TUSER]  = s00_axis_tlast & s00_axis_tuser;
    w_err[ERR_LENGTH] = s00_axis_tlast ? !w_at_len : w_at_len;
  end

  assign w_beat_err = |w_err;

  // Next-state, index tracking and event strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_len_nxt      = r_len;
    w_bad_nxt      = r_bad;
    w_flags_nxt    = r_err_flags;
    w_pkt_inc      = 1'b0;
    w_bad_pkt_inc  = 1'b0;
    w_beat_err_inc = 1'b0;

    case (r_state)
      HUNT: begin
        if (s00_axis_tvalid && s00_axis_tlast) begin
          w_state_nxt = CHECK;
          w_idx_nxt   = '0;
          w_bad_nxt   = 1'b0;
        end
      end
      CHECK: begin
        if (s00_axis_tvalid) begin
          w_len_nxt = w_len_cur;
          if (w_beat_err) begin
            w_beat_err_inc = 1'b1;
            w_flags_nxt    = r_err_flags | w_err;
          end
          if (s00_axis_tlast) begin
            w_pkt_inc     = 1'b1;
            w_bad_pkt_inc = r_bad | w_beat_err;
            w_idx_nxt     = '0;
            w_bad_nxt     = 1'b0;
          end else if (w_at_len) begin
            // Overlong packet: framing lost, resynchronise on the next tlast.
            w_state_nxt = HUNT;
            w_idx_nxt   = '0;
            w_bad_nxt   = 1'b0;
          end else begin
            w_idx_nxt = r_idx + IDX_WIDTH'(1);
            w_bad_nxt = r_bad | w_beat_err;
          end
        end
      end
      default: begin
        w_state_nxt = HUNT;
        w_idx_nxt   = '0;
        w_bad_nxt   = 1'b0;
      end
    endcase

    if (clear) begin
      w_flags_nxt = '0;
    end
  end

  // Checker state, packet tracking and sticky flags.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state     <= HUNT;
      r_idx       <= '0;
      r_len       <= '0;
      r_bad       <= 1'b0;
      r_err_flags <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_len       <= w_len_nxt;
      r_bad       <= w_bad_nxt;
      r_err_flags <= w_flags_nxt;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .i_clk   (s00_axis_aclk),
    .i_rst_n (s00_axis_aresetn),
    .i_clr   (clear),
    .i_inc   (w_pkt_inc),
    .o_count (pkt_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bad_pkt_cnt (
    .i_clk   (s00_axis_aclk),
    .i_rst_n (s00_axis_aresetn),
    .i_clr   (clear),
    .i_inc   (w_bad_pkt_inc),
    .o_count (bad_pkt_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_beat_err_cnt (
    .i_clk   (s00_axis_aclk),
    .i_rst_n (s00_axis_aresetn),
    .i_clr   (clear),
    .i_inc   (w_beat_err_inc),
    .o_count (beat_err_count)
  );

  assign locked    = (r_state == CHECK);
  assign err_flags = r_err_flags;

  // Low half of expected_data is the index field and carries no pattern.
  assign w_unused = &{1'b0, expected_data[PAT_LSB-1:0]};

endmodule

// File: tb/tb_eth_packet_checker.sv
// Directed self-checking bench for eth_packet_checker.
module tb_eth_packet_checker;

  localparam logic [47:0] PAT = 48'hA5A5_A5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic [15:0] packet_length;
  logic [63:0] expected_data;
  logic        clear;
  logic        locked;
  logic [31:0] pkt_count;
  logic [31:0] bad_pkt_count;
  logic [31:0] beat_err_count;
  logic [4:0]  err_flags;

  int n_checks = 0;
  int n_errors = 0;

  eth_packet_checker #(.CNT_WIDTH(32), .IDX_WIDTH(16)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (tdata),
    .s00_axis_tkeep   (tkeep),
    .s00_axis_tvalid  (tvalid),
    .s00_axis_tlast   (tlast),
    .s00_axis_tuser   (tuser),
    .packet_length    (packet_length),
    .expected_data    (expected_data),
    .clear            (clear),
    .locked           (locked),
    .pkt_count        (pkt_count),
    .bad_pkt_count    (bad_pkt_count),
    .beat_err_count   (beat_err_count),
    .err_flags        (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic lk, input int pc, input int bc,
                           input int ec, input logic [4:0] fl);
    check({tag, ".locked"}, 64'(locked), 64'(lk));
    check({tag, ".pkt"}, 64'(pkt_count), 64'(pc));
    check({tag, ".bad"}, 64'(bad_pkt_count), 64'(bc));
    check({tag, ".beat_err"}, 64'(beat_err_count), 64'(ec));
    check({tag, ".flags"}, 64'(err_flags), 64'(fl));
  endtask

  // One beat driven at a negedge; outputs reflect it at the following negedge.
  task automatic beat(input int idx, input logic last, input logic [7:0] keep = 8'hFF,
                      input logic user = 1'b0, input logic [63:0] flip = 64'd0);
    tdata  = {PAT, 16'(idx)} ^ flip;
    tkeep  = keep;
    tvalid = 1'b1;
    tlast  = last;
    tuser  = user;
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    tkeep  = 8'hFF;
    tdata  = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  task automatic pkt(input int last_idx);
    for (int i = 0; i <= last_idx; i++) beat(i, (i == last_idx));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    tdata         = '0;
    tkeep         = 8'hFF;
    tvalid        = 1'b0;
    tlast         = 1'b0;
    tuser         = 1'b0;
    clear         = 1'b0;
    packet_length = 16'd3;
    expected_data = {PAT, 16'h1234};
    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, 0, 0, 0, 5'b00000);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: partial packet then five clean ones; garbage while hunting is ignored.
    beat(2, 1'b0, 8'h00, 1'b0, 64'hFFFF_0000_0000_0000);
    check("t1.hunt_locked", 64'(locked), 64'd0);
    beat(3, 1'b1);
    check_all("t1.lock", 1'b1, 0, 0, 0, 5'b00000);
    repeat (5) pkt(3);
    check_all("t1.clean", 1'b1, 5, 0, 0, 5'b00000);

    // 2: bit 40 flipped on beat 2 of the third packet.
    pulse_clear();
    check_all("t2.clear", 1'b1, 0, 0, 0, 5'b00000);
    pkt(3);
    pkt(3);
    beat(0, 1'b0); beat(1, 1'b0);
    beat(2, 1'b0, 8'hFF, 1'b0, 64'd1 << 40);
    beat(3, 1'b1);
    check_all("t2.data", 1'b1, 3, 1, 1, 5'b00010);

    // 3: early tlast at index 1, then a clean packet.
    pulse_clear();
    beat(0, 1'b0); beat(1, 1'b1);
    check_all("t3.early", 1'b1, 1, 1, 1, 5'b01000);
    pkt(3);
    check_all("t3.after", 1'b1, 2, 1, 1, 5'b01000);

    // 4: missing tlast at index 3 drops lock; relock on next tlast.
    pulse_clear();
    for (int i = 0; i <= 3; i++) beat(i, 1'b0);
    check_all("t4.overlong", 1'b0, 0, 0, 1, 5'b01000);
    pkt(3);
    check_all("t4.relock", 1'b1, 0, 0, 1, 5'b01000);
    pkt(3);
    check_all("t4.clean", 1'b1, 1, 0, 1, 5'b01000);

    // 5: partial keep on beat 0 and tuser on tlast in one packet.
    pulse_clear();
    beat(0, 1'b0, 8'h0F);
    beat(1, 1'b0); beat(2, 1'b0);
    beat(3, 1'b1, 8'hFF, 1'b1);
    check_all("t5.keep_tuser", 1'b1, 1, 1, 2, 5'b10100);

    // 6: length change mid-packet only applies to the next packet.
    pulse_clear();
    beat(0, 1'b0);
    packet_length = 16'd7;
    beat(1, 1'b0); beat(2, 1'b0); beat(3, 1'b1);
    check_all("t6.len_held", 1'b1, 1, 0, 0, 5'b00000);
    // Clear coincident with a counted tlast: clear wins.
    for (int i = 0; i < 7; i++) beat(i, 1'b0);
    clear = 1'b1;
    beat(7, 1'b1);
    clear = 1'b0;
    check_all("t6.clear_wins", 1'b1, 0, 0, 0, 5'b00000);
    pkt(7);
    check("t6.len7_pkt", 64'(pkt_count), 64'd1);
    // Reset mid-packet returns to reset values at once, resync through HUNT.
    beat(0, 1'b0); beat(1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all("t6.reset", 1'b0, 0, 0, 0, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    beat(2, 1'b0);
    check("t6.hunt", 64'(locked), 64'd0);
    for (int i = 3; i <= 7; i++) beat(i, (i == 7));
    check_all("t6.relock", 1'b1, 0, 0, 0, 5'b00000);
    pkt(7);
    check_all("t6.resume", 1'b1, 1, 0, 0, 5'b00000);

    // 7: zero length, every beat is a single-beat packet.
    packet_length = 16'd0;
    repeat (3) beat(0, 1'b1);
    check_all("t7.len0", 1'b1, 4, 0, 0, 5'b00000);
    beat(0, 1'b0);
    check_all("t7.len0_overlong", 1'b0, 4, 0, 1, 5'b01000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
